// File: rtl/pass_entry_seq_pkg.sv
// Shared definitions for the lock front end: FSM encoding, digit geometry
// and default timing so the comparators and the sequencer agree on widths.
package pass_entry_seq_pkg;

   localparam int DIGITS        = 5;
   localparam int DW            = 4;
   localparam int DEF_MAX_FAIL  = 3;
   localparam int DEF_IDLE_TO   = 1000;
   localparam int DEF_OPEN_CYC  = 500;
   localparam int DEF_LOCK_CYC  = 2000;

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      EVAL    = 2'd1,
      OPEN    = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   // Largest of three timing constants, used to size the shared timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pass_entry_seq_if.sv
// Keypad/comparator/status bundle between the sequencer and its environment.
interface pass_entry_seq_if;
   import pass_entry_seq_pkg::*;

   logic          key_valid;
   logic [DW-1:0] key_code;
   logic          key_clr;
   logic          match1;
   logic          match2;
   logic [DW-1:0] d0;
   logic [DW-1:0] d1;
   logic [DW-1:0] d2;
   logic [DW-1:0] d3;
   logic [DW-1:0] d4;
   logic          cmp_valid;
   logic          alarm;
   logic          unlock;
   logic          lockout;
   logic [1:0]    fail_cnt;

   // The sequencer side.
   modport slave (
      input  key_valid, key_code, key_clr, match1, match2,
      output d0, d1, d2, d3, d4, cmp_valid, alarm, unlock, lockout, fail_cnt
   );

   // Keypad driver / comparator side.
   modport master (
      output key_valid, key_code, key_clr, match1, match2,
      input  d0, d1, d2, d3, d4, cmp_valid, alarm, unlock, lockout, fail_cnt
   );

endinterface

// File: rtl/pass_entry_seq_timer.sv
// Lock timer: load a cycle count, count down to zero, flag the last cycle.
// One instance is time-shared by the idle, open and lockout phases.
module pass_entry_seq_timer #(
   parameter int TW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [TW-1:0] i_val,
   output logic          o_done
);

   logic [TW-1:0] r_cnt;

   // Down-counter; a load always overrides counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Terminal count: a phase loaded with N ends after exactly N cycles.
   assign o_done = (r_cnt == TW'(1));

endmodule

// File: rtl/pass_entry_seq.sv
// Sequential front end of the two-stage lock: collects five key digits,
// runs one compare cycle, tracks failures/alarm and times unlock/lockout.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ENTRY   | collecting digits; idle timeout discards a partial entry
//  EVAL    | one cycle, cmp_valid=1, comparator result sampled
//  OPEN    | unlock held for OPEN_CYC cycles
//  LOCKOUT | keypad disabled for LOCK_CYC cycles, alarm kept
module pass_entry_seq
   import pass_entry_seq_pkg::*;
#(
   parameter int MAX_FAIL = DEF_MAX_FAIL,
   parameter int IDLE_TO  = DEF_IDLE_TO,
   parameter int OPEN_CYC = DEF_OPEN_CYC,
   parameter int LOCK_CYC = DEF_LOCK_CYC
) (
   input  logic            clk,
   input  logic            rst,
   pass_entry_seq_if.slave bus
);

   localparam int             TW       = $clog2(max3(IDLE_TO, OPEN_CYC, LOCK_CYC) + 1);
   localparam int             IW       = $clog2(DIGITS);
   localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);

   state_t        r_state;
   logic [DW-1:0] r_d [DIGITS];
   logic [IW-1:0] r_idx;
   logic          r_cmp_valid;
   logic          r_alarm;
   logic          r_unlock;
   logic          r_lockout;
   logic [1:0]    r_fail_cnt;

   logic          w_key;
   logic          w_m;
   logic          w_tmr_load;
   logic [TW-1:0] w_tmr_val;
   logic          w_tmr_done;

   // key_clr beats a simultaneous key strobe.
   assign w_key = bus.key_valid & ~bus.key_clr;
   // Once alarm is up the second-password comparator owns the decision.
   assign w_m   = r_alarm ? bus.match2 : bus.match1;

   // Timer load selection: every accepted key restarts the idle window,
   // EVAL loads the length of whichever timed phase follows (0 = none).
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      case (r_state)
         ENTRY: begin
            if (w_key) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(IDLE_TO);
            end
         end
         EVAL: begin
            w_tmr_load = 1'b1;
            if (w_m)          w_tmr_val = TW'(OPEN_CYC);
            else if (r_alarm) w_tmr_val = TW'(LOCK_CYC);
         end
         default: ;
      endcase
   end

   pass_entry_seq_timer #(.TW(TW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_tmr_load),
      .i_val  (w_tmr_val),
      .o_done (w_tmr_done)
   );

   // Main sequencer: state, digit capture, failure count and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ENTRY;
         r_idx       <= '0;
         r_cmp_valid <= 1'b0;
         r_alarm     <= 1'b0;
         r_unlock    <= 1'b0;
         r_lockout   <= 1'b0;
         r_fail_cnt  <= '0;
         for (int i = 0; i < DIGITS; i++) r_d[i] <= '0;
      end else begin
         case (r_state)
            ENTRY: begin
               if (bus.key_clr || (!bus.key_valid && r_idx != '0 && w_tmr_done)) begin
                  r_idx <= '0;
                  for (int i = 0; i < DIGITS; i++) r_d[i] <= '0;
               end else if (bus.key_valid) begin
                  r_d[r_idx] <= bus.key_code;
                  if (r_idx == LAST_IDX) begin
                     r_state     <= EVAL;
                     r_cmp_valid <= 1'b1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            EVAL: begin
               r_cmp_valid <= 1'b0;
               r_idx       <= '0;
               for (int i = 0; i < DIGITS; i++) r_d[i] <= '0;
               if (w_m) begin
                  r_state    <= OPEN;
                  r_unlock   <= 1'b1;
                  r_fail_cnt <= '0;
               end else if (r_alarm) begin
                  r_state   <= LOCKOUT;
                  r_lockout <= 1'b1;
               end else if (int'(r_fail_cnt) + 1 >= MAX_FAIL) begin
                  r_state    <= ENTRY;
                  r_alarm    <= 1'b1;
                  r_fail_cnt <= '0;
               end else begin
                  r_state    <= ENTRY;
                  r_fail_cnt <= r_fail_cnt + 1'b1;
               end
            end
            OPEN: begin
               if (w_tmr_done) begin
                  r_state  <= ENTRY;
                  r_unlock <= 1'b0;
                  r_alarm  <= 1'b0;
               end
            end
            LOCKOUT: begin
               if (w_tmr_done) begin
                  r_state   <= ENTRY;
                  r_lockout <= 1'b0;
               end
            end
            default: r_state <= ENTRY;
         endcase
      end
   end

   assign bus.d0        = r_d[0];
   assign bus.d1        = r_d[1];
   assign bus.d2        = r_d[2];
   assign bus.d3        = r_d[3];
   assign bus.d4        = r_d[4];
   assign bus.cmp_valid = r_cmp_valid;
   assign bus.alarm     = r_alarm;
   assign bus.unlock    = r_unlock;
   assign bus.lockout   = r_lockout;
   assign bus.fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_pass_entry_seq.sv
// Directed bench for the lock entry sequencer (short timing constants).
module tb_pass_entry_seq;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   pass_entry_seq_if bus ();

   pass_entry_seq #(
      .MAX_FAIL (3),
      .IDLE_TO  (8),
      .OPEN_CYC (4),
      .LOCK_CYC (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] digits();
      return {bus.d0, bus.d1, bus.d2, bus.d3, bus.d4};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] c);
      bus.key_valid = 1'b1;
      bus.key_code  = c;
      tick();
      bus.key_valid = 1'b0;
   endtask

   task automatic enter5(input logic [19:0] codes);
      for (int i = 0; i < 5; i++) press(codes[19-4*i -: 4]);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      if (digits() !== 20'h0) begin $display("FAIL reset_digits: got %h expected 00000", digits()); n_err++; end n_vec++;
      if ({bus.cmp_valid, bus.alarm, bus.unlock, bus.lockout} !== 4'b0) begin $display("FAIL reset_flags: got %b expected 0000", {bus.cmp_valid, bus.alarm, bus.unlock, bus.lockout}); n_err++; end n_vec++;
      if (bus.fail_cnt !== 2'd0) begin $display("FAIL reset_fail_cnt: got %0d expected 0", bus.fail_cnt); n_err++; end n_vec++;
   endtask

   task automatic test_open();
      bus.match1 = 1'b1;
      enter5(20'h12345);
      if (digits() !== 20'h12345) begin $display("FAIL open_digits: got %h expected 12345", digits()); n_err++; end n_vec++;
      if (bus.cmp_valid !== 1'b1 || bus.unlock !== 1'b0) begin $display("FAIL open_eval: got cmp_valid=%b unlock=%b expected 1 0", bus.cmp_valid, bus.unlock); n_err++; end n_vec++;
      tick();
      if (bus.cmp_valid !== 1'b0 || bus.unlock !== 1'b1) begin $display("FAIL open_first: got cmp_valid=%b unlock=%b expected 0 1", bus.cmp_valid, bus.unlock); n_err++; end n_vec++;
      if (digits() !== 20'h0) begin $display("FAIL open_cleared: got %h expected 00000", digits()); n_err++; end n_vec++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.unlock !== 1'b1) begin $display("FAIL open_hold%0d: got unlock=%b expected 1", i, bus.unlock); n_err++; end n_vec++;
      end
      tick();
      if (bus.unlock !== 1'b0 || bus.fail_cnt !== 2'd0) begin $display("FAIL open_end: got unlock=%b fail_cnt=%0d expected 0 0", bus.unlock, bus.fail_cnt); n_err++; end n_vec++;
      bus.match1 = 1'b0;
   endtask

   task automatic test_ignore_keys();
      bus.match1 = 1'b1;
      enter5(20'h11111);
      bus.key_valid = 1'b1;
      bus.key_code  = 4'd9;
      tick();
      if (digits() !== 20'h0 || bus.unlock !== 1'b1) begin $display("FAIL ign_eval: got d=%h unlock=%b expected 00000 1", digits(), bus.unlock); n_err++; end n_vec++;
      for (int i = 0; i < 4; i++) tick();
      if (digits() !== 20'h0 || bus.unlock !== 1'b0) begin $display("FAIL ign_open: got d=%h unlock=%b expected 00000 0", digits(), bus.unlock); n_err++; end n_vec++;
      bus.key_valid = 1'b0;
      bus.match1    = 1'b0;
      press(4'd3);
      if (digits() !== 20'h30000) begin $display("FAIL ign_idx: got %h expected 30000", digits()); n_err++; end n_vec++;
      bus.key_clr = 1'b1;
      tick();
      bus.key_clr = 1'b0;
   endtask

   task automatic test_fail_alarm();
      bus.match1 = 1'b0;
      bus.match2 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         enter5(20'h99999);
         tick();
         if (bus.fail_cnt !== ((k < 3) ? 2'(k) : 2'd0)) begin $display("FAIL fail_cnt%0d: got %0d expected %0d", k, bus.fail_cnt, (k < 3) ? k : 0); n_err++; end n_vec++;
         if (bus.alarm !== (k == 3) || bus.unlock !== 1'b0) begin $display("FAIL alarm%0d: got alarm=%b unlock=%b expected %b 0", k, bus.alarm, bus.unlock, (k == 3)); n_err++; end n_vec++;
      end
      bus.match2 = 1'b1;
      enter5(20'h24680);
      if (bus.cmp_valid !== 1'b1) begin $display("FAIL stage2_eval: got cmp_valid=%b expected 1", bus.cmp_valid); n_err++; end n_vec++;
      tick();
      if (bus.unlock !== 1'b1 || bus.alarm !== 1'b1) begin $display("FAIL stage2_open: got unlock=%b alarm=%b expected 1 1", bus.unlock, bus.alarm); n_err++; end n_vec++;
      for (int i = 0; i < 4; i++) tick();
      if (bus.unlock !== 1'b0 || bus.alarm !== 1'b0) begin $display("FAIL stage2_end: got unlock=%b alarm=%b expected 0 0", bus.unlock, bus.alarm); n_err++; end n_vec++;
      bus.match2 = 1'b0;
   endtask

   task automatic test_idle();
      bus.match1 = 1'b0;
      enter5(20'h99999);
      tick();
      if (bus.fail_cnt !== 2'd1) begin $display("FAIL idle_pre_fail: got %0d expected 1", bus.fail_cnt); n_err++; end n_vec++;
      press(4'd7);
      press(4'd7);
      for (int i = 0; i < 7; i++) tick();
      if (digits() !== 20'h77000) begin $display("FAIL idle_early: got %h expected 77000", digits()); n_err++; end n_vec++;
      tick();
      if (digits() !== 20'h0) begin $display("FAIL idle_discard: got %h expected 00000", digits()); n_err++; end n_vec++;
      if (bus.fail_cnt !== 2'd1) begin $display("FAIL idle_fail_cnt: got %0d expected 1", bus.fail_cnt); n_err++; end n_vec++;
      press(4'd4);
      if (digits() !== 20'h40000) begin $display("FAIL idle_idx: got %h expected 40000", digits()); n_err++; end n_vec++;
      bus.key_valid = 1'b1;
      bus.key_clr   = 1'b1;
      bus.key_code  = 4'd5;
      tick();
      bus.key_valid = 1'b0;
      bus.key_clr   = 1'b0;
      if (digits() !== 20'h0) begin $display("FAIL clr_wins: got %h expected 00000", digits()); n_err++; end n_vec++;
      press(4'd2);
      if (digits() !== 20'h20000) begin $display("FAIL clr_idx: got %h expected 20000", digits()); n_err++; end n_vec++;
      bus.key_clr = 1'b1;
      tick();
      bus.key_clr = 1'b0;
   endtask

   task automatic test_lockout();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.match1 = 1'b0;
      bus.match2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         enter5(20'h99999);
         tick();
      end
      if (bus.alarm !== 1'b1) begin $display("FAIL lock_alarm: got %b expected 1", bus.alarm); n_err++; end n_vec++;
      enter5(20'h55555);
      tick();
      if (bus.lockout !== 1'b1 || bus.cmp_valid !== 1'b0) begin $display("FAIL lock_first: got lockout=%b cmp_valid=%b expected 1 0", bus.lockout, bus.cmp_valid); n_err++; end n_vec++;
      bus.key_valid = 1'b1;
      bus.key_code  = 4'd6;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.lockout !== 1'b1 || digits() !== 20'h0) begin $display("FAIL lock_hold%0d: got lockout=%b d=%h expected 1 00000", i, bus.lockout, digits()); n_err++; end n_vec++;
      end
      tick();
      bus.key_valid = 1'b0;
      if (bus.lockout !== 1'b0 || bus.alarm !== 1'b1) begin $display("FAIL lock_end: got lockout=%b alarm=%b expected 0 1", bus.lockout, bus.alarm); n_err++; end n_vec++;
      press(4'd1);
      if (digits() !== 20'h10000) begin $display("FAIL lock_keys_back: got %h expected 10000", digits()); n_err++; end n_vec++;
      bus.key_clr = 1'b1;
      tick();
      bus.key_clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus.match2 = 1'b0;
      enter5(20'h55555);
      tick();
      tick();
      if (bus.lockout !== 1'b1) begin $display("FAIL rst_lock_pre: got lockout=%b expected 1", bus.lockout); n_err++; end n_vec++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if ({digits(), bus.cmp_valid, bus.alarm, bus.unlock, bus.lockout, bus.fail_cnt} !== 26'h0) begin $display("FAIL rst_lock: got d=%h flags=%b fail=%0d expected all zero", digits(), {bus.cmp_valid, bus.alarm, bus.unlock, bus.lockout}, bus.fail_cnt); n_err++; end n_vec++;
      bus.match1 = 1'b1;
      enter5(20'h12345);
      tick();
      tick();
      if (bus.unlock !== 1'b1) begin $display("FAIL rst_open_pre: got unlock=%b expected 1", bus.unlock); n_err++; end n_vec++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if ({digits(), bus.cmp_valid, bus.alarm, bus.unlock, bus.lockout, bus.fail_cnt} !== 26'h0) begin $display("FAIL rst_open: got d=%h flags=%b fail=%0d expected all zero", digits(), {bus.cmp_valid, bus.alarm, bus.unlock, bus.lockout}, bus.fail_cnt); n_err++; end n_vec++;
      bus.match1 = 1'b0;
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      rst           = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_code  = '0;
      bus.key_clr   = 1'b0;
      bus.match1    = 1'b0;
      bus.match2    = 1'b0;
      test_reset();
      test_open();
      test_ignore_keys();
      test_fail_alarm();
      test_idle();
      test_lockout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within 200000 time units");
      $fatal(1);
   end

endmodule
